// File: rtl/result_collector.sv
// Result collector: queues solver completions into a first-word-fall-through FIFO,
// tracks issued-but-unsolved tasks and keeps sticky drop/error accounting.
module result_collector #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 16
) (
  input  logic                      iCLOCK,
  input  logic                      inRESET,
  input  logic                      iSOLVED,
  input  logic [15:0]               iTASKID,
  input  logic [7:0]                iRES,
  input  logic [2:0]                iSLOT,
  input  logic                      iISSUE,
  input  logic                      iCLEAR,
  input  logic                      iRREADY,
  output logic                      oRVALID,
  output logic [26:0]               oRDATA,
  output logic [$clog2(DEPTH):0]    oCOUNT,
  output logic [CNTW-1:0]           oOUTSTANDING,
  output logic                      oIDLE,
  output logic                      oOVERFLOW,
  output logic [CNTW-1:0]           oDROPCNT,
  output logic                      oERROR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);
  localparam logic [CNTW-1:0] CntMax = '1;

  logic [26:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CNTW-1:0] out_q, out_d;
  logic [CNTW-1:0] dropcnt_q, dropcnt_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            idle_q, idle_d;

  logic empty, full, push, pop, drop, err_evt;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign pop     = !empty && iRREADY;
  // A full FIFO still accepts the new result when the head leaves in the same cycle.
  assign push    = iSOLVED && (!full || pop);
  assign drop    = iSOLVED && full && !pop;

  assign oRVALID      = !empty;
  assign oRDATA       = empty ? '0 : mem_q[rd_ptr_q];
  assign oCOUNT       = count_q;
  assign oOUTSTANDING = out_q;
  assign oIDLE        = idle_q;
  assign oOVERFLOW    = ovf_q;
  assign oDROPCNT     = dropcnt_q;
  assign oERROR       = err_q;

  // Entry storage; contents are never observed while empty so no reset is needed.
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {iSLOT, iTASKID, iRES};
    end
  end

  // Next-state for pointers, occupancy, outstanding count and sticky accounting.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    out_d     = out_q;
    err_evt   = 1'b0;
    ovf_d     = ovf_q;
    dropcnt_d = dropcnt_q;
    err_d     = err_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (pop && !push) count_d = count_q - (AW + 1)'(1);

    // Issue and solve together cancel out and are a legitimate solve.
    if (iISSUE && !iSOLVED) begin
      if (out_q != CntMax) out_d = out_q + CNTW'(1);
    end else if (iSOLVED && !iISSUE) begin
      if (out_q == '0) err_evt = 1'b1;
      else             out_d   = out_q - CNTW'(1);
    end

    // A drop or error in the clearing cycle wins over the clear.
    if (drop) begin
      ovf_d     = 1'b1;
      if (iCLEAR)                dropcnt_d = CNTW'(1);
      else if (dropcnt_q != CntMax) dropcnt_d = dropcnt_q + CNTW'(1);
    end else if (iCLEAR) begin
      ovf_d     = 1'b0;
      dropcnt_d = '0;
    end

    if (err_evt)     err_d = 1'b1;
    else if (iCLEAR) err_d = 1'b0;

    idle_d = (out_d == '0) && (count_d == '0);
  end

  // State registers with asynchronous reset; reset discards all queued entries.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      dropcnt_q <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_q     <= out_d;
      dropcnt_q <= dropcnt_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      idle_q    <= idle_d;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: queue-based reference model, scoreboard of expected
// FIFO entries, directed scenarios followed by randomized traffic.
module tb_result_collector;

  localparam int DEPTH = 16;
  localparam int CNTW  = 16;
  localparam longint MAXC = (64'd1 << CNTW) - 1;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iSOLVED = 1'b0;
  logic [15:0] iTASKID = '0;
  logic [7:0]  iRES = '0;
  logic [2:0]  iSLOT = '0;
  logic        iISSUE = 1'b0;
  logic        iCLEAR = 1'b0;
  logic        iRREADY = 1'b0;
  logic        oRVALID;
  logic [26:0] oRDATA;
  logic [4:0]  oCOUNT;
  logic [15:0] oOUTSTANDING;
  logic        oIDLE;
  logic        oOVERFLOW;
  logic [15:0] oDROPCNT;
  logic        oERROR;

  result_collector #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iSOLVED(iSOLVED), .iTASKID(iTASKID),
    .iRES(iRES), .iSLOT(iSLOT), .iISSUE(iISSUE), .iCLEAR(iCLEAR), .iRREADY(iRREADY),
    .oRVALID(oRVALID), .oRDATA(oRDATA), .oCOUNT(oCOUNT), .oOUTSTANDING(oOUTSTANDING),
    .oIDLE(oIDLE), .oOVERFLOW(oOVERFLOW), .oDROPCNT(oDROPCNT), .oERROR(oERROR)
  );

  always #5 iCLOCK = ~iCLOCK;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state visible after the most recent edge (m_) and after the pending one (n_).
  longint m_count, m_out, m_drop, n_count, n_out, n_drop;
  bit     m_ovf, m_err, m_idle, n_ovf, n_err, n_idle;
  logic [26:0] sb[$];

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_count = 0; m_out = 0; m_drop = 0; m_ovf = 0; m_err = 0; m_idle = 1;
    n_count = 0; n_out = 0; n_drop = 0; n_ovf = 0; n_err = 0; n_idle = 1;
  endfunction

  // One clock: retire the previous cycle into the model, then apply new inputs.
  task automatic step(input bit iss, input bit sol, input logic [15:0] tid,
                      input logic [7:0] r, input logic [2:0] sl, input bit rr, input bit clr);
    bit pop, push, drop, err_e;
    @(posedge iCLOCK);
    #1;
    m_count = n_count; m_out = n_out; m_drop = n_drop;
    m_ovf = n_ovf; m_err = n_err; m_idle = n_idle;
    iISSUE = iss; iSOLVED = sol; iTASKID = tid; iRES = r; iSLOT = sl;
    iRREADY = rr; iCLEAR = clr;
    pop  = (m_count > 0) && rr;
    push = sol && ((m_count < DEPTH) || pop);
    drop = sol && !push;
    n_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
    if (push) sb.push_back({sl, tid, r});
    err_e = 0;
    n_out = m_out;
    if (iss && !sol) n_out = (m_out == MAXC) ? m_out : m_out + 1;
    else if (sol && !iss) begin
      if (m_out == 0) err_e = 1;
      else n_out = m_out - 1;
    end
    n_ovf  = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    n_drop = drop ? (clr ? 1 : ((m_drop == MAXC) ? m_drop : m_drop + 1)) : (clr ? 0 : m_drop);
    n_err  = err_e ? 1'b1 : (clr ? 1'b0 : m_err);
    n_idle = (n_out == 0) && (n_count == 0);
  endtask

  task automatic idle_step(input bit rr);
    step(0, 0, '0, '0, '0, rr, 0);
  endtask

  task automatic release_reset();
    model_reset();
    @(negedge iCLOCK);
    inRESET = 1'b1;
    chk_en = 1'b1;
  endtask

  // Monitor: compares status against the model and pops the scoreboard on each handshake.
  always @(negedge iCLOCK) begin
    if (chk_en) begin
      check("rvalid", oRVALID, m_count != 0);
      check("count", oCOUNT, m_count);
      check("outstanding", oOUTSTANDING, m_out);
      check("idle", oIDLE, m_idle);
      check("overflow", oOVERFLOW, m_ovf);
      check("dropcnt", oDROPCNT, m_drop);
      check("error", oERROR, m_err);
      if (oRVALID) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          check("rdata_head", oRDATA, sb[0]);
          if (iRREADY) void'(sb.pop_front());
        end
      end else begin
        check("rdata_empty", oRDATA, 0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_pct;
    model_reset();
    #12;
    release_reset();

    // Idle after reset, then two issues.
    idle_step(0);
    idle_step(0);
    step(1, 0, '0, '0, '0, 0, 0);
    step(1, 0, '0, '0, '0, 0, 0);
    idle_step(0);
    check("two_issues", oOUTSTANDING, 2);
    step(0, 1, 16'h0001, 8'h00, 3'd0, 1, 0);
    step(0, 1, 16'h0002, 8'h00, 3'd0, 1, 0);
    idle_step(1);
    idle_step(1);

    // Single issue/solve with a negative score held at the head.
    step(1, 0, '0, '0, '0, 0, 0);
    step(0, 1, 16'h0005, 8'hF4, 3'd3, 0, 0);
    idle_step(0);
    check("single_rdata", oRDATA, {3'd3, 16'h0005, 8'hF4});
    check("single_out", oOUTSTANDING, 0);
    idle_step(1);
    idle_step(0);
    check("single_idle", oIDLE, 1);

    // Issue 20, solve 17 without draining: one drop.
    for (int i = 0; i < 20; i++) step(1, 0, '0, '0, '0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 16'(i), 8'(i * 3), 3'(i), 0, 0);
    idle_step(0);
    check("full_count", oCOUNT, 16);
    check("full_ovf", oOVERFLOW, 1);
    check("full_drop", oDROPCNT, 1);
    check("full_out", oOUTSTANDING, 3);

    // Full with simultaneous pop and push: no drop, then drain across the wrap.
    step(0, 1, 16'd100, 8'h40, 3'd7, 1, 0);
    idle_step(0);
    check("fullpp_count", oCOUNT, 16);
    check("fullpp_drop", oDROPCNT, 1);
    for (int i = 0; i < 18; i++) idle_step(1);

    // Drain the outstanding count, then an unmatched solve flags an error.
    step(0, 1, 16'd101, 8'hC0, 3'd1, 1, 0);
    step(0, 1, 16'd102, 8'h01, 3'd2, 1, 0);
    step(0, 1, 16'd103, 8'h7F, 3'd4, 1, 0);
    idle_step(1);
    check("err_flag", oERROR, 1);
    check("err_out", oOUTSTANDING, 0);
    step(0, 0, '0, '0, '0, 1, 1);
    idle_step(1);
    check("clr_err", oERROR, 0);
    check("clr_ovf", oOVERFLOW, 0);
    check("clr_drop", oDROPCNT, 0);

    // Drop and clear in the same cycle: the drop wins with a count of one.
    for (int i = 0; i < 17; i++) step(1, 1, 16'(300 + i), 8'(i), 3'(i), 0, i == 16);
    idle_step(0);
    check("dropclr_drop", oDROPCNT, 1);
    for (int i = 0; i < 18; i++) idle_step(1);

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++) step(1, 1, 16'(200 + i), 8'(i), 3'(i), 0, 0);
    step(1, 0, '0, '0, '0, 0, 0);
    idle_step(0);
    check("pre_rst_count", oCOUNT, 5);
    #2;
    chk_en = 1'b0;
    iISSUE = 0; iSOLVED = 0; iRREADY = 0; iCLEAR = 0;
    inRESET = 1'b0;
    #1;
    check("arst_rvalid", oRVALID, 0);
    check("arst_count", oCOUNT, 0);
    check("arst_out", oOUTSTANDING, 0);
    check("arst_idle", oIDLE, 1);
    release_reset();

    // Randomized traffic with alternating slow and fast consumers.
    for (int i = 0; i < 3000; i++) begin
      rr_pct = ((i % 400) < 200) ? 20 : 75;
      step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 50, 16'($urandom),
           8'($urandom), 3'($urandom), $urandom_range(0, 99) < rr_pct,
           $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 20; i++) idle_step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Sits directly downstream of the Othello solver pipeline.
- Samples the pipeline's per-cycle completion outputs (solved, task id, result, slot id) and queues each completed task into a FIFO for readout by the host/interconnect side.
- Tracks the number of outstanding (issued but unsolved) tasks so the controller knows when the solver is idle.
- The pipeline cannot be stalled, so results arriving at a full FIFO are dropped and accounted for.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
CNTW, 16, width of the outstanding and overflow counters.

Ports:
iCLOCK  input  1  system clock; all state updates on its rising edge.
inRESET  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
iSOLVED  input  1  pipeline completion strobe; one cycle per solved task.
iTASKID  input  16  task id accompanying iSOLVED.
iRES  input  8  signed final score accompanying iSOLVED (-64..64).
iSLOT  input  3  pipeline slot (stack id) accompanying iSOLVED.
iISSUE  input  1  one-cycle pulse when upstream hands a new task into the pipeline.
iCLEAR  input  1  synchronous clear of sticky flags and the overflow counter.
iRREADY  input  1  consumer ready.
oRVALID  output  1  FIFO head valid.
oRDATA  output  27  head entry {slot[26:24], taskid[23:8], res[7:0]}.
oCOUNT  output  log2(DEPTH)+1  current FIFO occupancy.
oOUTSTANDING  output  CNTW  tasks issued but not yet solved.
oIDLE  output  1  high when oOUTSTANDING==0 and FIFO empty.
oOVERFLOW  output  1  sticky: at least one result dropped.
oDROPCNT  output  CNTW  saturating count of dropped results.
oERROR  output  1  sticky: iSOLVED seen with oOUTSTANDING==0.

Behaviour:
- Reset (inRESET low, asynchronous):
  - Pointers and occupancy go to 0; oRVALID=0; oRDATA=0; oCOUNT=0.
  - oOUTSTANDING=0; oIDLE=1; oOVERFLOW=0; oDROPCNT=0; oERROR=0.
  - Reset asserted mid-operation discards all queued entries; FIFO contents are not read after reset.
- Push:
  - When iSOLVED=1, the entry {iSLOT, iTASKID, iRES} is written at the rising edge if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Latency: sample at edge N; oRVALID=1 and oRDATA valid after edge N (FWFT from an empty FIFO).
- Pop:
  - Occurs when oRVALID && iRREADY at the rising edge; the read pointer advances.
  - oRDATA is driven combinationally from the register array at the read pointer and is 0 when empty.
  - oRDATA and oRVALID hold stable while oRVALID && !iRREADY.
- Simultaneous push and pop:
  - Occupancy is unchanged; both are performed in every case, including full and including empty-is-impossible-to-pop (an empty FIFO has no pop).
  - Push into an empty FIFO with iRREADY=1: the entry is not bypassed; it appears on the next cycle.
- Full, push, no pop:
  - The entry is dropped and oOVERFLOW is set.
  - oDROPCNT increments and saturates at all-ones.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is tracked separately (0..DEPTH).
- Outstanding counter:
  - iISSUE alone: +1, saturating at all-ones.
  - iSOLVED alone: -1. If it is already 0, it holds at 0 and oERROR is set.
  - Both in the same cycle: unchanged. This still counts as a valid solve, so no error.
  - A dropped result still decrements the counter, because the task is solved.
- oIDLE is registered, recomputed each cycle from the next-state outstanding count and occupancy.
- iCLEAR:
  - Clears oOVERFLOW, oERROR and oDROPCNT on the next edge.
  - If a drop or error occurs in the same cycle, the flag is set and the count is 1; the event wins over the clear.
  - iCLEAR does not affect FIFO contents or oOUTSTANDING.
- iRES is stored verbatim; no sign manipulation. iSOLVED outside of valid pipeline operation is treated identically.

Test Plan:
- Reset then idle → all outputs 0 except oIDLE=1. Pulse iISSUE twice → oOUTSTANDING=2, oIDLE=0.
- iISSUE once, then iSOLVED with iTASKID=16'h0005, iRES=-8'sd12, iSLOT=3, iRREADY=0 → next cycle oRVALID=1, oRDATA={3'd3,16'h0005,8'hF4}, oCOUNT=1, oOUTSTANDING=0. Raise iRREADY one cycle → oRVALID=0, oIDLE=1.
- Issue 20, solve 17 back-to-back with iRREADY=0, DEPTH=16 → oCOUNT=16, oOVERFLOW=1, oDROPCNT=1, oOUTSTANDING=3. Entries read out in order with task ids 0..15.
- FIFO full with iRREADY=1 and iSOLVED on the same cycle → no drop, oCOUNT stays 16, order preserved across pointer wrap (drain 16 plus later entries correctly).
- iSOLVED with oOUTSTANDING=0 → oERROR=1, counter stays 0. iCLEAR → oERROR=0, oOVERFLOW=0, oDROPCNT=0 next cycle.
- Assert inRESET mid-stream with oCOUNT=5 → immediately oRVALID=0, oCOUNT=0, oOUTSTANDING=0, asynchronously without waiting for a clock edge.
